m68k_bus_responder: RTL and testbench

Slave-side responder for the 68000 bus driven by the fx68k-based CPU wrapper. It detects AS/DS bus cycles, forwards them to a backend memory port over a req/ack handshake, and returns read data. It generates nDTACK after programmable wait states, and nBERR on backend timeout. It also recognises interrupt-acknowledge cycles and answers them with nVPA (autovector), reporting the acknowledged level to the interrupt controller.

---
 rtl/m68k_bus_pkg.sv | 17 +
 rtl/m68k_bus_responder.sv | 179 +++++++++++++++++
 tb/tb_m68k_bus_responder.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/m68k_bus_pkg.sv
// Shared types and constants for the 68000 slave-side bus responder.
package m68k_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_ACK  = 3'd3,
        ST_IACK = 3'd4,
        ST_BERR = 3'd5
    } state_e;

    localparam logic [2:0]  FC_INT_ACK   = 3'b111;
    localparam logic [19:0] IACK_ADDR_HI = 20'hFFFFF;
    localparam logic [15:0] DATAIN_RST   = 16'hFFFF;

endpackage

// File: rtl/m68k_bus_responder.sv
// 68000 bus slave: forwards AS/DS cycles to a req/ack backend, answers with
// nDTACK after optional wait states, nBERR on timeout, nVPA on interrupt acknowledge.
module m68k_bus_responder
    import m68k_bus_pkg::*;
#(
    parameter int WAIT_STATES = 0,
    parameter int TIMEOUT     = 255
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        CLK_EN_68K_P,
    input  logic        CLK_EN_68K_N,
    input  logic [23:1] M68K_ADDR,
    input  logic [15:0] M68K_DATAOUT,
    output logic [15:0] M68K_DATAIN,
    input  logic        nAS,
    input  logic        nUDS,
    input  logic        nLDS,
    input  logic        M68K_RW,
    input  logic        FC2,
    input  logic        FC1,
    input  logic        FC0,
    output logic        nDTACK,
    output logic        nVPA,
    output logic        nBERR,
    output logic        MEM_REQ,
    output logic [23:1] MEM_ADDR,
    output logic        MEM_WE,
    output logic [1:0]  MEM_BE,
    output logic [15:0] MEM_WDATA,
    input  logic [15:0] MEM_RDATA,
    input  logic        MEM_ACK,
    output logic        IACK_STB,
    output logic [2:0]  IACK_LEVEL
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
    localparam logic [7:0] WS_LAST = 8'(WAIT_STATES - 1);

    state_e      state_q;
    logic [7:0]  cnt_q;
    logic        aborted_q;
    logic [15:0] datain_q;
    logic        dtack_n_q;
    logic        vpa_n_q;
    logic        berr_n_q;
    logic        mem_req_q;
    logic [23:1] mem_addr_q;
    logic        mem_we_q;
    logic [1:0]  mem_be_q;
    logic [15:0] mem_wdata_q;
    logic        iack_stb_q;
    logic [2:0]  iack_level_q;

    logic cyc_start;
    logic is_iack;
    logic unused_clk_en_n;

    // phi2 enable is not needed: every bus decision is taken on phi1.
    assign unused_clk_en_n = CLK_EN_68K_N;

    assign cyc_start = CLK_EN_68K_P && !nAS && (!nUDS || !nLDS);
    assign is_iack   = ({FC2, FC1, FC0} == FC_INT_ACK) && (M68K_ADDR[23:4] == IACK_ADDR_HI);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 8'd0;
            aborted_q    <= 1'b0;
            datain_q     <= DATAIN_RST;
            dtack_n_q    <= 1'b1;
            vpa_n_q      <= 1'b1;
            berr_n_q     <= 1'b1;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
            mem_we_q     <= 1'b0;
            mem_be_q     <= 2'b00;
            mem_wdata_q  <= 16'h0000;
            iack_stb_q   <= 1'b0;
            iack_level_q <= 3'd0;
        end else begin
            iack_stb_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cyc_start) begin
                        if (is_iack) begin
                            vpa_n_q      <= 1'b0;
                            iack_stb_q   <= 1'b1;
                            iack_level_q <= M68K_ADDR[3:1];
                            state_q      <= ST_IACK;
                        end else begin
                            mem_addr_q  <= M68K_ADDR;
                            mem_we_q    <= ~M68K_RW;
                            mem_be_q    <= {~nUDS, ~nLDS};
                            mem_wdata_q <= M68K_DATAOUT;
                            mem_req_q   <= 1'b1;
                            cnt_q       <= 8'd0;
                            aborted_q   <= 1'b0;
                            state_q     <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    // Once the CPU drops AS the cycle is dead; the backend is still drained.
                    if (nAS) aborted_q <= 1'b1;
                    if (MEM_ACK) begin
                        mem_req_q <= 1'b0;
                        if (!mem_we_q) datain_q <= MEM_RDATA;
                        if (aborted_q || nAS) begin
                            state_q <= ST_IDLE;
                        end else if (WAIT_STATES == 0) begin
                            dtack_n_q <= 1'b0;
                            state_q   <= ST_ACK;
                        end else begin
                            cnt_q   <= 8'd0;
                            state_q <= ST_WAIT;
                        end
                    end else if (CLK_EN_68K_P) begin
                        if (cnt_q == TO_LAST) begin
                            mem_req_q <= 1'b0;
                            if (aborted_q || nAS) begin
                                state_q <= ST_IDLE;
                            end else begin
                                berr_n_q <= 1'b0;
                                state_q  <= ST_BERR;
                            end
                        end else begin
                            cnt_q <= cnt_q + 8'd1;
                        end
                    end
                end
                ST_WAIT: begin
                    if (nAS) begin
                        state_q <= ST_IDLE;
                    end else if (CLK_EN_68K_P) begin
                        if (cnt_q == WS_LAST) begin
                            dtack_n_q <= 1'b0;
                            state_q   <= ST_ACK;
                        end else begin
                            cnt_q <= cnt_q + 8'd1;
                        end
                    end
                end
                ST_ACK: begin
                    if (nAS) begin
                        dtack_n_q <= 1'b1;
                        state_q   <= ST_IDLE;
                    end
                end
                ST_IACK: begin
                    if (nAS) begin
                        vpa_n_q <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                end
                ST_BERR: begin
                    if (nAS) begin
                        berr_n_q <= 1'b1;
                        state_q  <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign M68K_DATAIN = datain_q;
    assign nDTACK      = dtack_n_q;
    assign nVPA        = vpa_n_q;
    assign nBERR       = berr_n_q;
    assign MEM_REQ     = mem_req_q;
    assign MEM_ADDR    = mem_addr_q;
    assign MEM_WE      = mem_we_q;
    assign MEM_BE      = mem_be_q;
    assign MEM_WDATA   = mem_wdata_q;
    assign IACK_STB    = iack_stb_q;
    assign IACK_LEVEL  = iack_level_q;

endmodule

// File: tb/tb_m68k_bus_responder.sv
// Directed bench for m68k_bus_responder: one instance with no wait states and a
// short timeout, one with two wait states; read data checked through a scoreboard.
module tb_m68k_bus_responder;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        en = 1'b1;
    logic        en_div = 1'b0;
    logic        clk_en_n = 1'b0;
    logic [23:1] addr;
    logic [15:0] dout;
    logic        nAS, nUDS, nLDS, RW, FC2, FC1, FC0;
    logic [15:0] rdata;
    logic        ack;

    logic [15:0] a_din, b_din;
    logic        a_dtack, a_vpa, a_berr, a_req, a_we, a_stb;
    logic        b_dtack, b_vpa, b_berr, b_req, b_we, b_stb;
    logic [23:1] a_addr, b_addr;
    logic [1:0]  a_be, b_be;
    logic [15:0] a_wdata, b_wdata;
    logic [2:0]  a_lvl, b_lvl;

    int checks = 0;
    int failures = 0;
    int tickcnt = 0;

    logic [15:0] sb_q[$];
    string       sb_tag[$];

    localparam int SEL_A_DTACK = 0;
    localparam int SEL_B_DTACK = 1;
    localparam int SEL_A_BERR  = 2;
    localparam int SEL_A_REQ   = 3;
    localparam int SEL_B_REQ   = 4;

    m68k_bus_responder #(.WAIT_STATES(0), .TIMEOUT(4)) dut_a (
        .CLK(CLK), .RESET(RESET), .CLK_EN_68K_P(en), .CLK_EN_68K_N(clk_en_n),
        .M68K_ADDR(addr), .M68K_DATAOUT(dout), .M68K_DATAIN(a_din),
        .nAS(nAS), .nUDS(nUDS), .nLDS(nLDS), .M68K_RW(RW),
        .FC2(FC2), .FC1(FC1), .FC0(FC0),
        .nDTACK(a_dtack), .nVPA(a_vpa), .nBERR(a_berr),
        .MEM_REQ(a_req), .MEM_ADDR(a_addr), .MEM_WE(a_we), .MEM_BE(a_be),
        .MEM_WDATA(a_wdata), .MEM_RDATA(rdata), .MEM_ACK(ack),
        .IACK_STB(a_stb), .IACK_LEVEL(a_lvl)
    );

    m68k_bus_responder #(.WAIT_STATES(2), .TIMEOUT(255)) dut_b (
        .CLK(CLK), .RESET(RESET), .CLK_EN_68K_P(en), .CLK_EN_68K_N(clk_en_n),
        .M68K_ADDR(addr), .M68K_DATAOUT(dout), .M68K_DATAIN(b_din),
        .nAS(nAS), .nUDS(nUDS), .nLDS(nLDS), .M68K_RW(RW),
        .FC2(FC2), .FC1(FC1), .FC0(FC0),
        .nDTACK(b_dtack), .nVPA(b_vpa), .nBERR(b_berr),
        .MEM_REQ(b_req), .MEM_ADDR(b_addr), .MEM_WE(b_we), .MEM_BE(b_be),
        .MEM_WDATA(b_wdata), .MEM_RDATA(rdata), .MEM_ACK(ack),
        .IACK_STB(b_stb), .IACK_LEVEL(b_lvl)
    );

    // Enable changes on the falling edge so it is stable at every rising edge.
    initial begin
        forever begin
            #5 CLK = 1'b1;
            #5 CLK = 1'b0;
            en = en_div ? ~en : 1'b1;
        end
    end

    always @(posedge CLK) begin
        if (en) tickcnt <= tickcnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "bench did not finish");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [15:0] val);
        sb_q.push_back(val);
        sb_tag.push_back(tag);
    endtask

    task automatic sb_check(input logic [15:0] obs);
        logic [15:0] exp;
        string tag;
        if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL sb_empty observed=%0h expected=queued_value", obs);
        end else begin
            exp = sb_q.pop_front();
            tag = sb_tag.pop_front();
            chk(tag, {16'h0, obs}, {16'h0, exp});
        end
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            SEL_A_DTACK: return a_dtack;
            SEL_B_DTACK: return b_dtack;
            SEL_A_BERR:  return a_berr;
            SEL_A_REQ:   return a_req;
            default:     return b_req;
        endcase
    endfunction

    task automatic wait_val(input string tag, input int sel, input logic val, input int max,
                            output int cyc);
        cyc = 0;
        while (sig(sel) !== val && cyc < max) begin
            @(negedge CLK);
            cyc++;
        end
        chk(tag, {31'h0, sig(sel)}, {31'h0, val});
    endtask

    initial begin
        int cyc;
        int t0;
        addr = '0; dout = 16'h0; nAS = 1'b1; nUDS = 1'b1; nLDS = 1'b1; RW = 1'b1;
        {FC2, FC1, FC0} = 3'b000; rdata = 16'h0; ack = 1'b0;
        RESET = 1'b1;
        repeat (2) @(negedge CLK);
        chk("rst_dtack", a_dtack, 1);
        chk("rst_vpa", a_vpa, 1);
        chk("rst_berr", a_berr, 1);
        chk("rst_req", a_req, 0);
        chk("rst_we", a_we, 0);
        chk("rst_be", a_be, 0);
        chk("rst_addr", a_addr, 0);
        chk("rst_wdata", a_wdata, 0);
        chk("rst_din", a_din, 16'hFFFF);
        chk("rst_stb", a_stb, 0);
        chk("rst_lvl", a_lvl, 0);
        RESET = 1'b0;
        @(negedge CLK);

        // Write-setup style AS without data strobes must not start a cycle.
        addr = 23'h000080; RW = 1'b1; {FC2, FC1, FC0} = 3'b101; nAS = 1'b0;
        repeat (2) @(negedge CLK);
        chk("setup_no_req", a_req, 0);

        // Word read, ack sampled on the third rising edge in REQ.
        nUDS = 1'b0; nLDS = 1'b0;
        @(negedge CLK);
        chk("rd_req", a_req, 1);
        chk("rd_addr", a_addr, 23'h000080);
        chk("rd_we", a_we, 0);
        chk("rd_be", a_be, 2'b11);
        chk("rd_b_req", b_req, 1);
        @(negedge CLK);
        chk("rd_req_hold1", a_req, 1);
        chk("rd_dtack_early", a_dtack, 1);
        @(negedge CLK);
        chk("rd_req_hold2", a_req, 1);
        ack = 1'b1; rdata = 16'h1234;
        sb_push("rd_a_din", 16'h1234);
        sb_push("rd_b_din", 16'h1234);
        @(negedge CLK);
        ack = 1'b0;
        chk("rd_dtack", a_dtack, 0);
        chk("rd_req_drop", a_req, 0);
        chk("rd_b_req_drop", b_req, 0);
        chk("rd_b_dtack_wait", b_dtack, 1);
        sb_check(a_din);
        wait_val("ws_b_dtack", SEL_B_DTACK, 1'b0, 10, cyc);
        chk("ws_b_clks", cyc, 2);
        sb_check(b_din);
        chk("rd_dtack_hold", a_dtack, 0);
        chk("rd_excl_berr", a_berr, 1);
        chk("rd_excl_vpa", a_vpa, 1);
        nAS = 1'b1; nUDS = 1'b1; nLDS = 1'b1;
        @(negedge CLK);
        chk("rd_dtack_rel", a_dtack, 1);
        chk("rd_b_dtack_rel", b_dtack, 1);

        // Upper-byte write; read data register must not change.
        @(negedge CLK);
        addr = 23'h100000; RW = 1'b0; dout = 16'hAB00; {FC2, FC1, FC0} = 3'b001;
        nAS = 1'b0; nUDS = 1'b0; nLDS = 1'b1;
        @(negedge CLK);
        chk("wr_we", a_we, 1);
        chk("wr_be", a_be, 2'b10);
        chk("wr_wdata", a_wdata, 16'hAB00);
        chk("wr_addr", a_addr, 23'h100000);
        chk("wr_req", a_req, 1);
        ack = 1'b1; rdata = 16'h5555;
        sb_push("wr_din_keep", 16'h1234);
        @(negedge CLK);
        ack = 1'b0;
        chk("wr_dtack", a_dtack, 0);
        sb_check(a_din);
        nAS = 1'b1; nUDS = 1'b1; nLDS = 1'b1; RW = 1'b1;
        repeat (2) @(negedge CLK);
        chk("wr_dtack_rel", a_dtack, 1);

        // Two wait states measured in phi1 ticks with phi1 at half the clock rate.
        en_div = 1'b1;
        repeat (2) @(negedge CLK);
        addr = 23'h000400; RW = 1'b1; {FC2, FC1, FC0} = 3'b101;
        nAS = 1'b0; nUDS = 1'b0; nLDS = 1'b0;
        wait_val("ws2_req", SEL_B_REQ, 1'b1, 10, cyc);
        ack = 1'b1; rdata = 16'hBEEF;
        sb_push("ws2_b_din", 16'hBEEF);
        @(negedge CLK);
        ack = 1'b0;
        t0 = tickcnt;
        wait_val("ws2_dtack", SEL_B_DTACK, 1'b0, 20, cyc);
        chk("ws2_ticks", tickcnt - t0, 2);
        sb_check(b_din);
        nAS = 1'b1; nUDS = 1'b1; nLDS = 1'b1;
        repeat (2) @(negedge CLK);
        chk("ws2_dtack_rel", b_dtack, 1);

        // Timeout after four phi1 ticks on the TIMEOUT=4 instance.
        @(negedge CLK);
        addr = 23'h000600; nAS = 1'b0; nUDS = 1'b0; nLDS = 1'b0;
        wait_val("to_req", SEL_A_REQ, 1'b1, 10, cyc);
        t0 = tickcnt;
        wait_val("to_berr", SEL_A_BERR, 1'b0, 40, cyc);
        chk("to_ticks", tickcnt - t0, 4);
        chk("to_req_drop", a_req, 0);
        chk("to_excl_dtack", a_dtack, 1);
        chk("to_excl_vpa", a_vpa, 1);
        ack = 1'b1; rdata = 16'hDEAD;
        sb_push("to_late_ack_din", 16'hBEEF);
        @(negedge CLK);
        ack = 1'b0;
        sb_check(a_din);
        chk("to_berr_hold", a_berr, 0);
        chk("to_late_dtack", a_dtack, 1);
        nAS = 1'b1; nUDS = 1'b1; nLDS = 1'b1;
        @(negedge CLK);
        chk("to_berr_rel", a_berr, 1);
        @(negedge CLK);
        ack = 1'b1; rdata = 16'hDEAD;
        sb_push("idle_ack_din", 16'hBEEF);
        @(negedge CLK);
        ack = 1'b0;
        sb_check(a_din);
        chk("idle_ack_dtack", a_dtack, 1);
        chk("idle_ack_req", a_req, 0);
        en_div = 1'b0;
        repeat (3) @(negedge CLK);

        // Interrupt acknowledge for level 4.
        addr = 23'h7FFFFC; {FC2, FC1, FC0} = 3'b111; RW = 1'b1;
        nAS = 1'b0; nUDS = 1'b1; nLDS = 1'b0;
        @(negedge CLK);
        chk("iack_vpa", a_vpa, 0);
        chk("iack_stb", a_stb, 1);
        chk("iack_lvl", a_lvl, 3'd4);
        chk("iack_no_req", a_req, 0);
        chk("iack_no_dtack", a_dtack, 1);
        chk("iack_no_berr", a_berr, 1);
        @(negedge CLK);
        chk("iack_stb_pulse", a_stb, 0);
        chk("iack_vpa_hold", a_vpa, 0);
        nAS = 1'b1; nUDS = 1'b1; nLDS = 1'b1; {FC2, FC1, FC0} = 3'b000;
        @(negedge CLK);
        chk("iack_vpa_rel", a_vpa, 1);

        // Asynchronous reset in the middle of a request.
        @(negedge CLK);
        addr = 23'h000055; {FC2, FC1, FC0} = 3'b101; nAS = 1'b0; nUDS = 1'b0; nLDS = 1'b0;
        @(negedge CLK);
        chk("arst_pre_req", a_req, 1);
        #2 RESET = 1'b1;
        #1;
        chk("arst_req", a_req, 0);
        chk("arst_addr", a_addr, 0);
        chk("arst_din", a_din, 16'hFFFF);
        chk("arst_dtack", a_dtack, 1);
        chk("arst_be", a_be, 0);
        chk("arst_b_req", b_req, 0);
        nAS = 1'b1; nUDS = 1'b1; nLDS = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
        addr = 23'h000056; nAS = 1'b0; nUDS = 1'b0; nLDS = 1'b0;
        @(negedge CLK);
        chk("post_rst_req", a_req, 1);
        chk("post_rst_addr", a_addr, 23'h000056);
        ack = 1'b1; rdata = 16'h0F0F;
        sb_push("post_rst_din", 16'h0F0F);
        @(negedge CLK);
        ack = 1'b0;
        chk("post_rst_dtack", a_dtack, 0);
        sb_check(a_din);
        nAS = 1'b1; nUDS = 1'b1; nLDS = 1'b1;
        @(negedge CLK);
        chk("post_rst_dtack_rel", a_dtack, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
